// File: rtl/syn_lb_xtn_bridge_if.sv
// Bus bundle for the Avalon-MM to local-bus bridge.
// Holds the Avalon host side and the LB slave-port side.
// The bridge takes the slave modport: it is the Avalon slave and it drives the LB enables.
// The master modport is the environment: Avalon host plus LB register blocks.
interface syn_lb_xtn_bridge_if #(
   parameter int P_HST_ADDR_W = 20,
   parameter int P_DATA_W     = 32,
   parameter int P_LB_ADDR_W  = 16,
   parameter int P_NUM_CH     = 2
);
   // Avalon-MM host side
   logic                           av_read_ih;
   logic                           av_write_ih;
   logic [P_HST_ADDR_W-1:0]        av_addr_id;
   logic [P_DATA_W-1:0]            av_write_data_id;
   logic                           av_wait_req_oh;
   logic                           av_read_data_valid_oh;
   logic [P_DATA_W-1:0]            av_read_data_od;

   // Local-bus side, one enable/valid bit per channel
   logic [P_NUM_CH-1:0]            lb_rd_en_oh;
   logic [P_NUM_CH-1:0]            lb_wr_en_oh;
   logic [P_LB_ADDR_W-1:0]         lb_addr_od;
   logic [P_DATA_W-1:0]            lb_wr_data_od;
   logic [P_NUM_CH-1:0]            lb_rd_valid_id;
   logic [P_NUM_CH*P_DATA_W-1:0]   lb_rd_data_id;
   logic [P_NUM_CH-1:0]            lb_wr_valid_id;

   modport slave (
      input  av_read_ih, av_write_ih, av_addr_id, av_write_data_id,
      output av_wait_req_oh, av_read_data_valid_oh, av_read_data_od,
      output lb_rd_en_oh, lb_wr_en_oh, lb_addr_od, lb_wr_data_od,
      input  lb_rd_valid_id, lb_rd_data_id, lb_wr_valid_id
   );

   modport master (
      output av_read_ih, av_write_ih, av_addr_id, av_write_data_id,
      input  av_wait_req_oh, av_read_data_valid_oh, av_read_data_od,
      input  lb_rd_en_oh, lb_wr_en_oh, lb_addr_od, lb_wr_data_od,
      output lb_rd_valid_id, lb_rd_data_id, lb_wr_valid_id
   );
endinterface

// File: rtl/syn_lb_xtn_bridge.sv
// Single-clock Avalon-MM slave to multi-channel local-bus bridge.
// Host requests are queued in a small FIFO and executed one at a time.
// Each request goes to the LB port selected by the address channel field.
// A watchdog terminates transactions whose LB port never answers.
module syn_lb_xtn_bridge #(
   parameter int                  P_HST_ADDR_W = 20,
   parameter int                  P_DATA_W     = 32,
   parameter int                  P_LB_ADDR_W  = 16,
   parameter int                  P_NUM_CH     = 2,
   parameter int                  P_CH_SEL_W   = 1,
   parameter int                  P_FF_DEPTH   = 8,
   parameter int                  P_FF_PTR_W   = 3,
   parameter int                  P_TIMEOUT    = 255,
   parameter int                  P_TIMEOUT_W  = 8,
   parameter logic [P_DATA_W-1:0] P_ERR_DATA   = 32'hDEADBEEF
) (
   input  logic                  clk_ir,
   input  logic                  rst_il,
   syn_lb_xtn_bridge_if.slave    bus,
   output logic                  timeout_oh,
   output logic [15:0]           err_cnt_od
);

   // Channel-indexed views are padded to a power of two so any select value indexes safely.
   localparam int CH_SPAN  = 1 << P_CH_SEL_W;
   localparam int CH_LSB   = P_LB_ADDR_W + 2;
   localparam int ADDR_USE = CH_LSB + P_CH_SEL_W;
   localparam bit WDOG_EN  = (P_TIMEOUT != 0);
   localparam int TMO_LAST_I = (P_TIMEOUT > 0) ? P_TIMEOUT - 1 : 0;
   localparam logic [P_TIMEOUT_W-1:0] TMO_LAST = P_TIMEOUT_W'(TMO_LAST_I);
   localparam logic [P_FF_PTR_W:0]    FF_FULL  = (P_FF_PTR_W+1)'(P_FF_DEPTH);

   typedef struct packed {
      logic                    is_rd;
      logic [P_CH_SEL_W-1:0]   ch;
      logic [P_LB_ADDR_W-1:0]  addr;
      logic [P_DATA_W-1:0]     data;
   } req_t;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   // ---------------------------------------------------------------
   // Request FIFO
   // ---------------------------------------------------------------
   req_t                    fifo_mem [P_FF_DEPTH];
   logic [P_FF_PTR_W-1:0]   wr_ptr_reg;
   logic [P_FF_PTR_W-1:0]   rd_ptr_reg;
   logic [P_FF_PTR_W:0]     count_reg;
   logic                    ff_full;
   logic                    ff_empty;
   logic                    ff_push;
   logic                    ff_pop;
   req_t                    push_entry;
   req_t                    head;

   state_t                  state_reg, state_next;

   assign ff_full  = (count_reg == FF_FULL);
   assign ff_empty = (count_reg == '0);
   assign ff_push  = (bus.av_read_ih | bus.av_write_ih) & ~ff_full;
   assign ff_pop   = (state_reg == ST_IDLE) & ~ff_empty;

   // A simultaneous read+write strobe is queued as a read.
   assign push_entry.is_rd = bus.av_read_ih;
   assign push_entry.ch    = bus.av_addr_id[CH_LSB +: P_CH_SEL_W];
   assign push_entry.addr  = bus.av_addr_id[P_LB_ADDR_W+1:2];
   assign push_entry.data  = bus.av_write_data_id;

   // The head entry is captured straight into the LB output registers on pop.
   assign head = fifo_mem[rd_ptr_reg];

   // Byte-lane bits and anything above the channel field play no part in decode.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^bus.av_addr_id[1:0];
   generate
      if (P_HST_ADDR_W > ADDR_USE) begin : g_addr_msb
         logic unused_addr_msbs;
         assign unused_addr_msbs = ^bus.av_addr_id[P_HST_ADDR_W-1:ADDR_USE];
      end
   endgenerate

   // FIFO storage write; no reset so it maps onto RAM.
   always_ff @(posedge clk_ir) begin
      if (ff_push) begin
         fifo_mem[wr_ptr_reg] <= push_entry;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave the count alone.
   always_ff @(posedge clk_ir) begin
      if (!rst_il) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (ff_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (ff_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({ff_push, ff_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Per-channel response views
   // ---------------------------------------------------------------
   logic [P_DATA_W-1:0]  ch_rd_data [CH_SPAN];
   logic [CH_SPAN-1:0]   ch_rd_valid;
   logic [CH_SPAN-1:0]   ch_wr_valid;

   genvar gi;
   generate
      for (gi = 0; gi < CH_SPAN; gi++) begin : g_ch
         if (gi < P_NUM_CH) begin : g_real
            assign ch_rd_data[gi]  = bus.lb_rd_data_id[gi*P_DATA_W +: P_DATA_W];
            assign ch_rd_valid[gi] = bus.lb_rd_valid_id[gi];
            assign ch_wr_valid[gi] = bus.lb_wr_valid_id[gi];
         end else begin : g_pad
            assign ch_rd_data[gi]  = '0;
            assign ch_rd_valid[gi] = 1'b0;
            assign ch_wr_valid[gi] = 1'b0;
         end
      end
   endgenerate

   // ---------------------------------------------------------------
   // Transaction FSM and datapath
   // ---------------------------------------------------------------
   logic [P_NUM_CH-1:0]     rd_en_reg, rd_en_next;
   logic [P_NUM_CH-1:0]     wr_en_reg, wr_en_next;
   logic [P_LB_ADDR_W-1:0]  lb_addr_reg, lb_addr_next;
   logic [P_DATA_W-1:0]     lb_wr_data_reg, lb_wr_data_next;
   logic                    cur_is_rd_reg, cur_is_rd_next;
   logic [P_CH_SEL_W-1:0]   cur_ch_reg, cur_ch_next;
   logic [P_TIMEOUT_W-1:0]  timer_reg, timer_next;
   logic                    rd_valid_reg, rd_valid_next;
   logic [P_DATA_W-1:0]     rd_data_reg, rd_data_next;
   logic                    timeout_reg, timeout_next;
   logic [15:0]             err_cnt_reg, err_cnt_next;
   logic                    err_fire;

   // Next-state and output decode; only the active channel's valid is looked at.
   always_comb begin
      state_next      = state_reg;
      rd_en_next      = '0;
      wr_en_next      = '0;
      lb_addr_next    = lb_addr_reg;
      lb_wr_data_next = lb_wr_data_reg;
      cur_is_rd_next  = cur_is_rd_reg;
      cur_ch_next     = cur_ch_reg;
      timer_next      = timer_reg;
      rd_valid_next   = 1'b0;
      rd_data_next    = rd_data_reg;
      timeout_next    = 1'b0;
      err_cnt_next    = err_cnt_reg;
      err_fire        = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (!ff_empty) begin
               lb_addr_next    = head.addr;
               lb_wr_data_next = head.data;
               cur_is_rd_next  = head.is_rd;
               cur_ch_next     = head.ch;
               timer_next      = '0;
               if (int'(head.ch) < P_NUM_CH) begin
                  if (head.is_rd) rd_en_next = P_NUM_CH'(1) << head.ch;
                  else            wr_en_next = P_NUM_CH'(1) << head.ch;
                  state_next = ST_WAIT;
               end else begin
                  // Nonexistent port: finish at once as an error, no enable.
                  err_fire      = 1'b1;
                  rd_valid_next = head.is_rd;
                  if (head.is_rd) rd_data_next = P_ERR_DATA;
               end
            end
         end
         ST_WAIT: begin
            if (cur_is_rd_reg && ch_rd_valid[cur_ch_reg]) begin
               rd_valid_next = 1'b1;
               rd_data_next  = ch_rd_data[cur_ch_reg];
               state_next    = ST_IDLE;
            end else if (!cur_is_rd_reg && ch_wr_valid[cur_ch_reg]) begin
               state_next = ST_IDLE;
            end else if (WDOG_EN && (timer_reg == TMO_LAST)) begin
               err_fire      = 1'b1;
               rd_valid_next = cur_is_rd_reg;
               if (cur_is_rd_reg) rd_data_next = P_ERR_DATA;
               state_next    = ST_IDLE;
            end else if (WDOG_EN) begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (err_fire) begin
         timeout_next = 1'b1;
         if (err_cnt_reg != 16'hFFFF) err_cnt_next = err_cnt_reg + 16'd1;
      end
   end

   // State and output registers; reset drops any in-flight transaction.
   always_ff @(posedge clk_ir) begin
      if (!rst_il) begin
         state_reg      <= ST_IDLE;
         rd_en_reg      <= '0;
         wr_en_reg      <= '0;
         lb_addr_reg    <= '0;
         lb_wr_data_reg <= '0;
         cur_is_rd_reg  <= 1'b0;
         cur_ch_reg     <= '0;
         timer_reg      <= '0;
         rd_valid_reg   <= 1'b0;
         rd_data_reg    <= '0;
         timeout_reg    <= 1'b0;
         err_cnt_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         rd_en_reg      <= rd_en_next;
         wr_en_reg      <= wr_en_next;
         lb_addr_reg    <= lb_addr_next;
         lb_wr_data_reg <= lb_wr_data_next;
         cur_is_rd_reg  <= cur_is_rd_next;
         cur_ch_reg     <= cur_ch_next;
         timer_reg      <= timer_next;
         rd_valid_reg   <= rd_valid_next;
         rd_data_reg    <= rd_data_next;
         timeout_reg    <= timeout_next;
         err_cnt_reg    <= err_cnt_next;
      end
   end

   assign bus.av_wait_req_oh        = ff_full;
   assign bus.av_read_data_valid_oh = rd_valid_reg;
   assign bus.av_read_data_od       = rd_data_reg;
   assign bus.lb_rd_en_oh           = rd_en_reg;
   assign bus.lb_wr_en_oh           = wr_en_reg;
   assign bus.lb_addr_od            = lb_addr_reg;
   assign bus.lb_wr_data_od         = lb_wr_data_reg;
   assign timeout_oh                = timeout_reg;
   assign err_cnt_od                = err_cnt_reg;

endmodule

// File: tb/tb_syn_lb_xtn_bridge.sv
// Directed self-checking bench for syn_lb_xtn_bridge.
// Two channels with a 2-bit channel field, so address bit 19 selects a missing port.
module tb_syn_lb_xtn_bridge;

   localparam int DW = 32;

   logic        clk_ir = 1'b0;
   logic        rst_il = 1'b0;
   logic        timeout_oh;
   logic [15:0] err_cnt_od;
   int          checks = 0;
   int          errors = 0;

   syn_lb_xtn_bridge_if #(
      .P_HST_ADDR_W(20), .P_DATA_W(DW), .P_LB_ADDR_W(16), .P_NUM_CH(2)
   ) bus ();

   syn_lb_xtn_bridge #(
      .P_HST_ADDR_W(20), .P_DATA_W(DW), .P_LB_ADDR_W(16), .P_NUM_CH(2),
      .P_CH_SEL_W(2), .P_FF_DEPTH(8), .P_FF_PTR_W(3), .P_TIMEOUT(255),
      .P_TIMEOUT_W(8), .P_ERR_DATA(32'hDEADBEEF)
   ) dut (
      .clk_ir     (clk_ir),
      .rst_il     (rst_il),
      .bus        (bus),
      .timeout_oh (timeout_oh),
      .err_cnt_od (err_cnt_od)
   );

   always #5 clk_ir = ~clk_ir;

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk_ir);
      #1;
   endtask

   task automatic idle_inputs();
      bus.av_read_ih       = 1'b0;
      bus.av_write_ih      = 1'b0;
      bus.lb_rd_valid_id   = 2'b00;
      bus.lb_wr_valid_id   = 2'b00;
   endtask

   task automatic test_reset();
      rst_il = 1'b0;
      idle_inputs();
      tick();
      tick();
      checks++; if (bus.av_wait_req_oh !== 1'b0) begin errors++; $display("FAIL reset_wait_req: got %b expected 0", bus.av_wait_req_oh); end
      checks++; if (bus.av_read_data_valid_oh !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.av_read_data_valid_oh); end
      checks++; if (bus.av_read_data_od !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", bus.av_read_data_od); end
      checks++; if ((bus.lb_rd_en_oh | bus.lb_wr_en_oh) !== 2'b00) begin errors++; $display("FAIL reset_en: got rd %b wr %b expected 00", bus.lb_rd_en_oh, bus.lb_wr_en_oh); end
      checks++; if (bus.lb_addr_od !== 16'h0 || bus.lb_wr_data_od !== 32'h0) begin errors++; $display("FAIL reset_lb_bus: got addr %h data %h expected 0", bus.lb_addr_od, bus.lb_wr_data_od); end
      checks++; if (timeout_oh !== 1'b0 || err_cnt_od !== 16'h0) begin errors++; $display("FAIL reset_err: got timeout %b cnt %0d expected 0", timeout_oh, err_cnt_od); end
      rst_il = 1'b1;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_single_write();
      int rdv = 0;
      int ens = 0;
      bus.av_write_ih      = 1'b1;
      bus.av_addr_id       = 20'h00010;
      bus.av_write_data_id = 32'hA5A5A5A5;
      tick();
      bus.av_write_ih = 1'b0;
      tick();
      checks++; if (bus.lb_wr_en_oh !== 2'b01 || bus.lb_rd_en_oh !== 2'b00) begin errors++; $display("FAIL wr_en: got wr %b rd %b expected wr 01 rd 00", bus.lb_wr_en_oh, bus.lb_rd_en_oh); end
      checks++; if (bus.lb_addr_od !== 16'h0004) begin errors++; $display("FAIL wr_addr: got %h expected 0004", bus.lb_addr_od); end
      checks++; if (bus.lb_wr_data_od !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_data: got %h expected a5a5a5a5", bus.lb_wr_data_od); end
      tick();
      checks++; if (bus.lb_wr_en_oh !== 2'b00) begin errors++; $display("FAIL wr_en_pulse: got %b expected 00 one cycle after en", bus.lb_wr_en_oh); end
      bus.lb_wr_valid_id = 2'b01;
      tick();
      bus.lb_wr_valid_id = 2'b00;
      repeat (4) begin
         if (bus.av_read_data_valid_oh) rdv++;
         if ((bus.lb_wr_en_oh | bus.lb_rd_en_oh) != 2'b00) ens++;
         tick();
      end
      checks++; if (rdv !== 0 || ens !== 0) begin errors++; $display("FAIL wr_after: got %0d rd pulses %0d en pulses expected 0 0", rdv, ens); end
      $display("test_single_write done");
   endtask

   task automatic test_read_ch1();
      int early = 0;
      bus.av_read_ih = 1'b1;
      bus.av_addr_id = 20'h40008;
      tick();
      bus.av_read_ih = 1'b0;
      tick();
      checks++; if (bus.lb_rd_en_oh !== 2'b10 || bus.lb_wr_en_oh !== 2'b00) begin errors++; $display("FAIL rd1_en: got rd %b wr %b expected rd 10 wr 00", bus.lb_rd_en_oh, bus.lb_wr_en_oh); end
      checks++; if (bus.lb_addr_od !== 16'h0002) begin errors++; $display("FAIL rd1_addr: got %h expected 0002", bus.lb_addr_od); end
      // spurious valid on channel 0 while channel 1 is active
      bus.lb_rd_valid_id = 2'b01;
      bus.lb_rd_data_id[0 +: DW] = 32'hBAD0BAD0;
      repeat (3) begin
         tick();
         if (bus.av_read_data_valid_oh) early++;
         bus.lb_rd_valid_id = 2'b00;
      end
      checks++; if (early !== 0) begin errors++; $display("FAIL rd1_spurious: got %0d early valid pulses expected 0", early); end
      bus.lb_rd_valid_id = 2'b10;
      bus.lb_rd_data_id[DW +: DW] = 32'h12345678;
      tick();
      bus.lb_rd_valid_id = 2'b01;
      checks++; if (bus.av_read_data_valid_oh !== 1'b1 || bus.av_read_data_od !== 32'h12345678) begin errors++; $display("FAIL rd1_data: got valid %b data %h expected 1 12345678", bus.av_read_data_valid_oh, bus.av_read_data_od); end
      tick();
      bus.lb_rd_valid_id = 2'b00;
      checks++; if (bus.av_read_data_valid_oh !== 1'b0 || bus.av_read_data_od !== 32'h12345678) begin errors++; $display("FAIL rd1_hold: got valid %b data %h expected 0 12345678", bus.av_read_data_valid_oh, bus.av_read_data_od); end
      $display("test_read_ch1 done");
   endtask

   task automatic test_back_to_back();
      int acc = 0;
      int issued = 0;
      int budget = 0;
      bit release_slv = 1'b0;
      bit pending = 1'b0;
      bit accept;
      while (issued < 10 && budget < 200) begin
         if (bus.lb_wr_en_oh != 2'b00) begin
            checks++; if (bus.lb_addr_od !== 16'(issued) || bus.lb_wr_data_od !== 32'(32'h100 + issued)) begin errors++; $display("FAIL b2b_order: got addr %h data %h expected addr %h data %h", bus.lb_addr_od, bus.lb_wr_data_od, 16'(issued), 32'(32'h100 + issued)); end
            issued++;
            pending = 1'b1;
         end
         if (!release_slv && bus.av_wait_req_oh) begin
            release_slv = 1'b1;
            // 8 in the FIFO plus the one already issued and stalled
            checks++; if (acc !== 9 || issued !== 1) begin errors++; $display("FAIL b2b_full: got %0d accepted %0d issued at wait_req expected 9 1", acc, issued); end
         end
         bus.lb_wr_valid_id = (release_slv && pending) ? 2'b01 : 2'b00;
         if (release_slv && pending) pending = 1'b0;
         bus.av_write_ih      = (acc < 10);
         bus.av_addr_id       = 20'(acc << 2);
         bus.av_write_data_id = 32'(32'h100 + acc);
         accept = bus.av_write_ih && !bus.av_wait_req_oh;
         tick();
         if (accept) acc++;
         budget++;
      end
      idle_inputs();
      checks++; if (issued !== 10 || acc !== 10 || release_slv !== 1'b1) begin errors++; $display("FAIL b2b_total: got %0d issued %0d accepted stall %b expected 10 10 1", issued, acc, release_slv); end
      tick();
      $display("test_back_to_back done");
   endtask

   task automatic test_timeout();
      int n = 0;
      bus.av_read_ih = 1'b1;
      bus.av_addr_id = 20'h00020;
      tick();
      bus.av_read_ih = 1'b0;
      tick();
      checks++; if (bus.lb_rd_en_oh !== 2'b01) begin errors++; $display("FAIL tmo_en: got %b expected 01", bus.lb_rd_en_oh); end
      while (!timeout_oh && n < 400) begin
         tick();
         n++;
      end
      checks++; if (n !== 255) begin errors++; $display("FAIL tmo_delay: got %0d cycles expected 255", n); end
      checks++; if (bus.av_read_data_valid_oh !== 1'b1 || bus.av_read_data_od !== 32'hDEADBEEF) begin errors++; $display("FAIL tmo_data: got valid %b data %h expected 1 deadbeef", bus.av_read_data_valid_oh, bus.av_read_data_od); end
      checks++; if (err_cnt_od !== 16'd1) begin errors++; $display("FAIL tmo_cnt: got %0d expected 1", err_cnt_od); end
      tick();
      checks++; if (timeout_oh !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b expected 0", timeout_oh); end
      // valid coincident with the watchdog edge wins
      bus.av_read_ih = 1'b1;
      tick();
      bus.av_read_ih = 1'b0;
      tick();
      repeat (254) tick();
      bus.lb_rd_valid_id = 2'b01;
      bus.lb_rd_data_id[0 +: DW] = 32'hCAFEF00D;
      tick();
      bus.lb_rd_valid_id = 2'b00;
      checks++; if (bus.av_read_data_valid_oh !== 1'b1 || bus.av_read_data_od !== 32'hCAFEF00D) begin errors++; $display("FAIL coin_data: got valid %b data %h expected 1 cafef00d", bus.av_read_data_valid_oh, bus.av_read_data_od); end
      checks++; if (timeout_oh !== 1'b0 || err_cnt_od !== 16'd1) begin errors++; $display("FAIL coin_err: got timeout %b cnt %0d expected 0 1", timeout_oh, err_cnt_od); end
      tick();
      $display("test_timeout done");
   endtask

   task automatic test_both_and_bad_ch();
      int ens = 0;
      bus.av_read_ih       = 1'b1;
      bus.av_write_ih      = 1'b1;
      bus.av_addr_id       = 20'h0000C;
      bus.av_write_data_id = 32'hFFFF0000;
      tick();
      idle_inputs();
      tick();
      checks++; if (bus.lb_rd_en_oh !== 2'b01 || bus.lb_wr_en_oh !== 2'b00 || bus.lb_addr_od !== 16'h0003) begin errors++; $display("FAIL both_as_read: got rd %b wr %b addr %h expected 01 00 0003", bus.lb_rd_en_oh, bus.lb_wr_en_oh, bus.lb_addr_od); end
      bus.lb_rd_valid_id = 2'b01;
      bus.lb_rd_data_id[0 +: DW] = 32'h11223344;
      tick();
      bus.lb_rd_valid_id = 2'b00;
      checks++; if (bus.av_read_data_valid_oh !== 1'b1 || bus.av_read_data_od !== 32'h11223344) begin errors++; $display("FAIL both_data: got valid %b data %h expected 1 11223344", bus.av_read_data_valid_oh, bus.av_read_data_od); end
      // channel field = 2 on a two-port bridge
      bus.av_read_ih = 1'b1;
      bus.av_addr_id = 20'h80004;
      tick();
      bus.av_read_ih = 1'b0;
      tick();
      checks++; if (bus.av_read_data_valid_oh !== 1'b1 || bus.av_read_data_od !== 32'hDEADBEEF) begin errors++; $display("FAIL badch_data: got valid %b data %h expected 1 deadbeef", bus.av_read_data_valid_oh, bus.av_read_data_od); end
      checks++; if (timeout_oh !== 1'b1 || err_cnt_od !== 16'd2) begin errors++; $display("FAIL badch_err: got timeout %b cnt %0d expected 1 2", timeout_oh, err_cnt_od); end
      repeat (4) begin
         if ((bus.lb_rd_en_oh | bus.lb_wr_en_oh) != 2'b00) ens++;
         tick();
      end
      checks++; if (ens !== 0) begin errors++; $display("FAIL badch_en: got %0d en pulses expected 0", ens); end
      $display("test_both_and_bad_ch done");
   endtask

   task automatic test_reset_in_wait();
      int rdv = 0;
      int ens = 0;
      for (int i = 0; i < 4; i++) begin
         bus.av_read_ih = 1'b1;
         bus.av_addr_id = 20'(i << 2);
         tick();
      end
      bus.av_read_ih = 1'b0;
      tick();
      rst_il = 1'b0;
      tick();
      checks++; if ((bus.lb_rd_en_oh | bus.lb_wr_en_oh) !== 2'b00 || bus.lb_addr_od !== 16'h0) begin errors++; $display("FAIL rstw_lb: got rd %b wr %b addr %h expected 00 00 0", bus.lb_rd_en_oh, bus.lb_wr_en_oh, bus.lb_addr_od); end
      checks++; if (bus.av_read_data_od !== 32'h0 || bus.av_read_data_valid_oh !== 1'b0 || bus.av_wait_req_oh !== 1'b0) begin errors++; $display("FAIL rstw_av: got data %h valid %b wait %b expected 0 0 0", bus.av_read_data_od, bus.av_read_data_valid_oh, bus.av_wait_req_oh); end
      checks++; if (err_cnt_od !== 16'h0 || timeout_oh !== 1'b0) begin errors++; $display("FAIL rstw_err: got cnt %0d timeout %b expected 0 0", err_cnt_od, timeout_oh); end
      rst_il = 1'b1;
      bus.lb_rd_valid_id = 2'b01;
      bus.lb_rd_data_id[0 +: DW] = 32'h55555555;
      tick();
      bus.lb_rd_valid_id = 2'b00;
      repeat (4) begin
         if (bus.av_read_data_valid_oh) rdv++;
         if ((bus.lb_rd_en_oh | bus.lb_wr_en_oh) != 2'b00) ens++;
         tick();
      end
      checks++; if (rdv !== 0 || ens !== 0) begin errors++; $display("FAIL rstw_flush: got %0d rd pulses %0d en pulses expected 0 0", rdv, ens); end
      bus.av_read_ih = 1'b1;
      bus.av_addr_id = 20'h00020;
      tick();
      bus.av_read_ih = 1'b0;
      tick();
      checks++; if (bus.lb_rd_en_oh !== 2'b01 || bus.lb_addr_od !== 16'h0008) begin errors++; $display("FAIL rstw_next_en: got rd %b addr %h expected 01 0008", bus.lb_rd_en_oh, bus.lb_addr_od); end
      bus.lb_rd_valid_id = 2'b01;
      bus.lb_rd_data_id[0 +: DW] = 32'h77777777;
      tick();
      bus.lb_rd_valid_id = 2'b00;
      checks++; if (bus.av_read_data_valid_oh !== 1'b1 || bus.av_read_data_od !== 32'h77777777) begin errors++; $display("FAIL rstw_next_data: got valid %b data %h expected 1 77777777", bus.av_read_data_valid_oh, bus.av_read_data_od); end
      tick();
      $display("test_reset_in_wait done");
   endtask

   initial begin
      idle_inputs();
      bus.av_addr_id       = '0;
      bus.av_write_data_id = '0;
      bus.lb_rd_data_id    = '0;
      test_reset();
      test_single_write();
      test_read_ch1();
      test_back_to_back();
      test_timeout();
      test_both_and_bad_ch();
      test_reset_in_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/syn_lb_xtn_bridge.md
# syn_lb_xtn_bridge

Single-clock, multi-channel Avalon-MM slave to local-bus (LB) bridge. It buffers host transactions in a parametrised request FIFO and decodes a channel field from the host byte address. Each transaction is issued to one of P_NUM_CH LB slave ports, and the bridge waits for that port's response, with a watchdog that terminates hung transactions. It sits between the Avalon fabric and synchronous LB register blocks that share the fabric clock, where no CDC crossing is needed.

## Interface
- P_HST_ADDR_W, 20, Avalon byte-address width
- P_DATA_W, 32, host and LB data width
- P_LB_ADDR_W, 16, LB word-address width
- P_NUM_CH, 2, number of LB slave ports
- P_CH_SEL_W, 1, channel select width (ceil(log2(P_NUM_CH)), min 1)
- P_FF_DEPTH, 8, request FIFO depth (power of 2)
- P_FF_PTR_W, 3, log2(P_FF_DEPTH)
- P_TIMEOUT, 255, cycles to wait for an LB response; 0 disables the watchdog
- P_TIMEOUT_W, 8, timer width
- P_ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
- clk_ir  in  1  clock
- rst_il  in  1  synchronous reset, active-low
- av_read_ih  in  1  1->read transaction
- av_write_ih  in  1  1->write transaction
- av_addr_id  in  P_HST_ADDR_W  byte address
- av_write_data_id  in  P_DATA_W  write data
- av_wait_req_oh  out  1  1->stall; equals request FIFO full
- av_read_data_valid_oh  out  1  1->av_read_data_od valid, one-cycle pulse
- av_read_data_od  out  P_DATA_W  read data
- lb_rd_en_oh  out  P_NUM_CH  one-hot read enable, one-cycle pulse
- lb_wr_en_oh  out  P_NUM_CH  one-hot write enable, one-cycle pulse
- lb_addr_od  out  P_LB_ADDR_W  LB word address, shared by all channels
- lb_wr_data_od  out  P_DATA_W  write data, shared by all channels
- lb_rd_valid_id  in  P_NUM_CH  per-channel read response valid
- lb_rd_data_id  in  P_NUM_CH*P_DATA_W  per-channel read data; channel k occupies [k*P_DATA_W +: P_DATA_W]
- lb_wr_valid_id  in  P_NUM_CH  per-channel write acknowledge
- timeout_oh  out  1  one-cycle pulse when the watchdog fires
- err_cnt_od  out  16  saturating count of timeouts

## Operation
- Address decode:
  - lb_addr = av_addr_id[P_LB_ADDR_W+1:2]; byte offset bits [1:0] are discarded.
  - channel = av_addr_id[P_LB_ADDR_W+2 +: P_CH_SEL_W]; higher bits are ignored.
  - A channel index >= P_NUM_CH is not issued to any port. It is completed immediately as an error: reads return P_ERR_DATA, err_cnt increments, and timeout_oh pulses.
- Request FIFO entry is {is_rd, ch, lb_addr, wr_data}.
  - Push when (av_read_ih | av_write_ih) & ~full.
  - If read and write are asserted together, the entry is stored as a read.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states are IDLE and WAIT.
  - IDLE: if the FIFO is non-empty, pop the head, register the address, data and channel, pulse the selected en bit for one cycle, clear the timer, and go to WAIT.
  - WAIT: only the active channel's valid is observed; other channels' valids are ignored.
    - Read: on lb_rd_valid_id[ch], register that channel's data to av_read_data_od, pulse av_read_data_valid_oh, and go to IDLE.
    - Write: on lb_wr_valid_id[ch], go to IDLE.
    - Watchdog: the timer increments every WAIT cycle. When timer == P_TIMEOUT-1 with no valid, pulse timeout_oh, increment err_cnt (saturating at 16'hFFFF), return P_ERR_DATA with valid if the transaction is a read, and go to IDLE.
    - If valid and timeout occur in the same cycle, valid wins and no error is recorded.
- Valids arriving in IDLE are ignored.
- av_read_data_od holds its value between pulses.

## Timing
- Reset (rst_il low at a clock edge): all outputs are 0, including av_read_data_od, err_cnt_od, lb_addr_od and lb_wr_data_od. The FIFO is flushed, the FSM returns to IDLE, and in-flight transactions are dropped with no response.
- Host request accepted at edge E0 -> en pulse is high during the cycle after E1, provided the FSM is IDLE.
- An LB valid may be asserted in the same cycle as en or later; it is sampled at the following edge Ev.
- av_read_data_valid_oh is high during the cycle after Ev.
- The next en follows earliest one cycle after the bridge returns to IDLE, giving a peak throughput of 1 transaction per 2 cycles.
- av_wait_req_oh is driven from the registered FIFO count; it asserts the cycle after the P_FF_DEPTH-th unpopped push.
- With P_TIMEOUT=N, timeout_oh pulses N cycles after the en pulse.

## Test plan
- Single write, ch0, addr 0x00010, data 0xA5A5A5A5, wr_valid one cycle after en -> lb_wr_en_oh=2'b01 for 1 cycle, lb_addr_od=0x0004, lb_wr_data_od=0xA5A5A5A5, no read valid.
- Read from ch1 (addr bit 18 set, addr 0x40008), slave returns 0x12345678 after 3 cycles while ch0 asserts a spurious rd_valid -> one av_read_data_valid_oh pulse with 0x12345678; the spurious valid is ignored.
- Push 10 writes back-to-back with the slave stalled -> av_wait_req_oh asserts after 8 accepted entries; all 10 are issued in order once the slave responds.
- Read with no response, P_TIMEOUT=255 -> timeout_oh pulse 255 cycles after en, av_read_data_od=0xDEADBEEF with valid, err_cnt_od=1. Repeat with valid and timeout coincident -> slave data returned, err_cnt unchanged.
- Read and write asserted together, and a request to channel index 2 with P_NUM_CH=2 (issued with P_CH_SEL_W=2) -> first is issued as a read; second completes as an error without any en pulse.
- Reset asserted in WAIT with 3 entries queued, slave valid arriving after reset -> outputs zero, FIFO empty, no read-valid pulse, next request executes normally.
